// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and bit-level helper functions used by the
// stream core and its round datapath.
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPRESS,
    ST_FINAL,
    ST_HOLD
  } sha_state_e;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [255:0] SHA224_IV = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] Sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] Sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic logic [31:0] Ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] Maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Window holds W[t..t+15] with W[t] in the top word; returns W[t+16].
  function automatic logic [31:0] sched_next(input logic [511:0] win);
    return sigma1(win[63:32]) + win[223:192] + sigma0(win[479:448]) + win[511:480];
  endfunction

  function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; state packed as {a,b,c,d,e,f,g,h}
// with a in the top word.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] st_in,
  input  logic [31:0]  w,
  input  logic [31:0]  k,
  output logic [255:0] st_out
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = st_in;
  assign t1 = h + Sigma1(e) + Ch(e, f, g) + k + w;
  assign t2 = Sigma0(a) + Maj(a, b, c);
  assign st_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_stream_core.sv
// Block-streaming SHA-256/224 core: accepts padded 512-bit blocks, runs
// ROUNDS_PER_CYCLE rounds per clock and holds the digest until consumed.
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 2,
  parameter int SUPPORT_224      = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
  input  logic         in_last,
  input  logic         mode_224,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest,
  output logic         busy
);

  localparam logic [5:0] RND_STEP = 6'(ROUNDS_PER_CYCLE);
  localparam logic [5:0] RND_LAST = 6'(64 - ROUNDS_PER_CYCLE);

  sha_state_e   state_q, state_d;
  logic [5:0]   rnd_q, rnd_d;
  logic         last_q, last_d;
  logic         mode_q, mode_d;
  logic [255:0] h_q, h_d;
  logic [255:0] work_q, work_d;
  logic [511:0] win_q, win_d;

  logic         mode_in;
  logic [255:0] rounds_st;
  logic [511:0] rounds_win;

  assign mode_in = (SUPPORT_224 != 0) && mode_224;

  // Round chain: each stage consumes the window head and slides in W[t+16].
  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_rnd
    logic [255:0] st_in, st_out;
    logic [511:0] win_in, win_out;
    logic [5:0]   t_idx;

    if (j == 0) begin : g_head
      assign st_in  = work_q;
      assign win_in = win_q;
    end else begin : g_link
      assign st_in  = g_rnd[j-1].st_out;
      assign win_in = g_rnd[j-1].win_out;
    end

    assign t_idx   = rnd_q + 6'(j);
    assign win_out = {win_in[479:0], sched_next(win_in)};

    sha256_round u_round (
      .st_in  (st_in),
      .w      (win_in[511:480]),
      .k      (K[t_idx]),
      .st_out (st_out)
    );
  end

  assign rounds_st  = g_rnd[ROUNDS_PER_CYCLE-1].st_out;
  assign rounds_win = g_rnd[ROUNDS_PER_CYCLE-1].win_out;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    last_d  = last_q;
    mode_d  = mode_q;
    h_d     = h_q;
    work_d  = work_q;
    win_d   = win_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          win_d   = in_block;
          last_d  = in_last;
          rnd_d   = 6'd0;
          state_d = ST_COMPRESS;
          if (in_first) begin
            mode_d = mode_in;
            h_d    = mode_in ? SHA224_IV : SHA256_IV;
            work_d = mode_in ? SHA224_IV : SHA256_IV;
          end else begin
            work_d = h_q;
          end
        end
      end
      ST_COMPRESS: begin
        work_d = rounds_st;
        win_d  = rounds_win;
        // Counter parks on its final value instead of wrapping.
        if (rnd_q == RND_LAST) state_d = ST_FINAL;
        else                   rnd_d   = rnd_q + RND_STEP;
      end
      ST_FINAL: begin
        h_d     = add_words(h_q, work_q);
        state_d = last_q ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rnd_q   <= 6'd0;
      last_q  <= 1'b0;
      mode_q  <= 1'b0;
      h_q     <= SHA256_IV;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      last_q  <= last_d;
      mode_q  <= mode_d;
      h_q     <= h_d;
    end
  end

  // Working state and schedule window are only meaningful after an accept.
  always_ff @(posedge clk) begin
    work_q <= work_d;
    win_q  <= win_d;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);
  assign digest    = {h_q[255:32], (mode_q && state_q == ST_HOLD) ? 32'h0 : h_q[31:0]};

endmodule

// File: tb/tb_sha256_stream_core.sv
// Self-checking bench: known-answer and random messages against a plain
// SHA-256/224 reference model, plus reset-abort and multi-R handshake checks.
module tb_sha256_stream_core;

  localparam int LAT = 64 / 2 + 1;

  localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  localparam logic [255:0] ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO256 = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] ABC224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] EMPTY256 = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  logic [31:0] TK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk, reset;
  logic         in_valid, in_first, in_last, mode_224, out_ready;
  logic [511:0] in_block;
  logic         in_ready, out_valid, busy;
  logic [255:0] digest;

  logic [1:0]   aux_v, aux_or, aux_rdy, aux_ov, aux_busy;
  logic [255:0] aux_dg [2];

  int total = 0;
  int bad   = 0;

  byte unsigned msg[$];
  logic [511:0] blk_q[$];

  sha256_stream_core #(.ROUNDS_PER_CYCLE(2), .SUPPORT_224(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_first(in_first), .in_last(in_last), .mode_224(mode_224),
    .out_valid(out_valid), .out_ready(out_ready), .digest(digest), .busy(busy)
  );

  sha256_stream_core #(.ROUNDS_PER_CYCLE(1), .SUPPORT_224(1)) dut_r1 (
    .clk(clk), .reset(reset), .in_valid(aux_v[0]), .in_ready(aux_rdy[0]),
    .in_block(in_block), .in_first(in_first), .in_last(in_last), .mode_224(mode_224),
    .out_valid(aux_ov[0]), .out_ready(aux_or[0]), .digest(aux_dg[0]), .busy(aux_busy[0])
  );

  sha256_stream_core #(.ROUNDS_PER_CYCLE(4), .SUPPORT_224(1)) dut_r4 (
    .clk(clk), .reset(reset), .in_valid(aux_v[1]), .in_ready(aux_rdy[1]),
    .in_block(in_block), .in_first(in_first), .in_last(in_last), .mode_224(mode_224),
    .out_valid(aux_ov[1]), .out_ready(aux_or[1]), .digest(aux_dg[1]), .busy(aux_busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  task automatic build_blocks();
    byte unsigned p[$];
    longint unsigned bits;
    logic [511:0] x;
    p = msg;
    bits = longint'(msg.size()) * 8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8*i)));
    blk_q.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) x[511 - 8*j -: 8] = p[64*b + j];
      blk_q.push_back(x);
    end
  endtask

  function automatic logic [255:0] ref_digest(input logic m224);
    logic [255:0] hh;
    hh = m224 ? IV224 : IV256;
    foreach (blk_q[i]) hh = ref_compress(hh, blk_q[i]);
    return m224 ? {hh[255:32], 32'h0} : hh;
  endfunction

  task automatic load_str(input string s);
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(8'(s[i]));
    build_blocks();
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] x;
    for (int i = 0; i < 16; i++) x[32*i +: 32] = $urandom;
    return x;
  endfunction

  task automatic send_msg(input string tag, input logic m224, input logic first_flag,
                          input logic [255:0] want, input int hold_cyc);
    int n;
    logic is_last;
    for (int i = 0; i < blk_q.size(); i++) begin
      n = 0;
      while (in_ready !== 1'b1 && n < 200) begin step(); n++; end
      chk({tag, " ready"}, in_ready, 1);
      is_last  = (i == blk_q.size() - 1);
      in_valid = 1'b1;
      in_block = blk_q[i];
      in_first = (i == 0) ? first_flag : 1'b0;
      in_last  = is_last;
      mode_224 = m224;
      step();
      in_valid = 1'b0;
      in_block = rand_block();
      in_first = 1'($urandom);
      in_last  = 1'($urandom);
      mode_224 = 1'($urandom);
      chk({tag, " busy"}, busy, 1);
      chk({tag, " not_ready"}, in_ready, 0);
      n = 0;
      while (!(is_last ? out_valid : in_ready) && n < 200) begin
        in_valid = (n + 2 < LAT) ? 1'($urandom) : 1'b0;
        step();
        n++;
      end
      in_valid = 1'b0;
      chk({tag, " latency"}, n, LAT);
    end
    chk({tag, " out_valid"}, out_valid, 1);
    chk({tag, " digest"}, digest, want);
    for (int c = 0; c < hold_cyc; c++) begin
      step();
      chk({tag, " hold_digest"}, digest, want);
      chk({tag, " hold_ready"}, in_ready, 0);
      chk({tag, " hold_valid"}, out_valid, 1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " released"}, out_valid, 0);
    chk({tag, " idle_ready"}, in_ready, 1);
  endtask

  task automatic run_aux(input int k, input int lat);
    int n;
    load_str("");
    in_block = blk_q[0];
    in_first = 1'b1;
    in_last  = 1'b1;
    mode_224 = 1'b0;
    chk("aux ready", aux_rdy[k], 1);
    aux_v[k] = 1'b1;
    step();
    aux_v[k] = 1'b0;
    n = 0;
    while (!aux_ov[k] && n < 200) begin step(); n++; end
    chk("aux latency", n, lat);
    for (int c = 0; c < 10; c++) begin
      chk("aux hold_digest", aux_dg[k], EMPTY256);
      chk("aux hold_ready", aux_rdy[k], 0);
      step();
    end
    chk("aux hold_end", aux_dg[k], EMPTY256);
    aux_or[k] = 1'b1;
    step();
    aux_or[k] = 1'b0;
    chk("aux released", aux_ov[k], 0);
    chk("aux idle_ready", aux_rdy[k], 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic seen;
    reset = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    mode_224 = 1'b0; out_ready = 1'b0; in_block = '0; aux_v = '0; aux_or = '0;
    step(); step();
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst digest", digest, IV256);
    reset = 1'b1;

    load_str("abc");
    send_msg("abc256", 1'b0, 1'b1, ABC256, 3);
    load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    send_msg("two_block", 1'b0, 1'b1, TWO256, 0);
    load_str("abc");
    send_msg("abc224", 1'b1, 1'b1, ABC224, 2);
    load_str("");
    send_msg("empty_r2", 1'b0, 1'b1, EMPTY256, 10);
    run_aux(0, 65);
    run_aux(1, 17);

    // abort mid-compress, then a clean message
    load_str("abc");
    in_valid = 1'b1; in_block = blk_q[0]; in_first = 1'b1; in_last = 1'b1; mode_224 = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    reset = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort out_valid", out_valid, 0);
    chk("abort digest", digest, IV256);
    step();
    reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin step(); seen |= out_valid; end
    chk("abort no_spurious", seen, 0);
    send_msg("abc_after_abort", 1'b0, 1'b1, ABC256, 1);

    // first accept after reset without in_first uses the SHA-256 IV
    reset = 1'b0;
    step();
    reset = 1'b1;
    send_msg("abc_nofirst", 1'b1, 1'b0, ABC256, 1);

    for (int m = 0; m < 8; m++) begin
      int len;
      logic md;
      len = $urandom_range(0, 140);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      build_blocks();
      md = 1'($urandom);
      send_msg("random", md, 1'b1, ref_digest(md), $urandom_range(0, 5));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
